tray_move_sched: RTL and testbench

- Shares the tray mechanism between NREQ requesters and sequences one move at a time.
- Arbitrates queued 4-bit tray commands round-robin and drives the tray command bus (icou) with a fixed-length pulse.
- Monitors the tray_height feedback from the tray module until it is stable, then reports completion and final height, or a timeout error.
- Sits between the host/command sources and the tray module, in place of direct command wiring.

---
 rtl/tray_pkg.sv | 14 +
 rtl/tray_rr_arb.sv | 37 +++
 rtl/tray_move_sched.sv | 154 +++++++++++++++
 tb/tb_tray_move_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tray_pkg.sv
// Shared types and constants for the tray move scheduler.
package tray_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_MONITOR,
        ST_REPORT
    } state_t;

    localparam logic [3:0] CMD_NOP    = 4'h0;
    localparam int         HW_DEFAULT = 32;

endpackage

// File: rtl/tray_rr_arb.sv
// Round-robin pick of the first request at or after i_ptr, wrapping; purely combinational.
// Zero latency; no backpressure of its own, the caller decides whether a grant is taken.
module tray_rr_arb #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int off = 0; off < NREQ; off++) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(off);
            if (w_sum >= (IW+1)'(NREQ)) begin
                w_sum = w_sum - (IW+1)'(NREQ);
            end
            w_pos = w_sum[IW-1:0];
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

endmodule

// File: rtl/tray_move_sched.sv
// Arbitrates tray commands round-robin, pulses icou, waits for tray_height to settle, reports done/err.
// Move latency 1+CMD_PULSE+SETTLE_CYC+1 cycles (query 2); one request in flight, others wait unacknowledged.
module tray_move_sched
    import tray_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int CMD_PULSE   = 2,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 4096,
    parameter int HW          = HW_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [4*NREQ-1:0]       req_cmd,
    output logic [NREQ-1:0]         req_ready,
    output logic [3:0]              icou,
    input  logic [HW-1:0]           tray_height,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic [HW-1:0]           done_height,
    output logic                    err
);

    localparam int IW = $clog2(NREQ);
    localparam int PW = $clog2(CMD_PULSE + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_id;
    logic [3:0]    r_cmd;
    logic          r_ok;
    logic [PW-1:0] r_pulse;
    logic [SW-1:0] r_stable;
    logic [TW-1:0] r_tmo;
    logic [HW-1:0] r_prev_h;

    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_gidx;
    logic            w_gany;
    logic [3:0]      w_cmd_sel;
    logic [IW-1:0]   w_ptr_nxt;
    logic            w_accept;
    logic            w_pulse_last;
    logic [SW-1:0]   w_stable_nxt;
    logic [TW-1:0]   w_tmo_nxt;
    logic            w_settled;
    logic            w_timed_out;

    tray_rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_gany)
    );

    assign w_accept     = (r_state == ST_IDLE) && w_gany;
    assign w_cmd_sel    = req_cmd[{w_gidx, 2'b00} +: 4];
    assign w_ptr_nxt    = (w_gidx == IW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
    assign w_pulse_last = (r_pulse == PW'(CMD_PULSE - 1));

    // Both counters include the current cycle, so a match here exits MONITOR on this edge.
    assign w_stable_nxt = (tray_height != r_prev_h)       ? '0 :
                          (r_stable == SW'(SETTLE_CYC))   ? r_stable :
                                                            r_stable + 1'b1;
    assign w_tmo_nxt    = (r_tmo == TW'(TIMEOUT_CYC)) ? r_tmo : r_tmo + 1'b1;
    assign w_settled    = (w_stable_nxt == SW'(SETTLE_CYC));
    assign w_timed_out  = (w_tmo_nxt == TW'(TIMEOUT_CYC));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gany) begin
                    w_state_nxt = (w_cmd_sel == CMD_NOP) ? ST_REPORT : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_pulse_last) begin
                    w_state_nxt = ST_MONITOR;
                end
            end
            ST_MONITOR: begin
                if (w_settled || w_timed_out) begin
                    w_state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_id     <= '0;
            r_cmd    <= CMD_NOP;
            r_ok     <= 1'b0;
            r_pulse  <= '0;
            r_stable <= '0;
            r_tmo    <= '0;
            r_prev_h <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_prev_h <= tray_height;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd   <= w_cmd_sel;
                        r_id    <= w_gidx;
                        r_ptr   <= w_ptr_nxt;
                        r_ok    <= 1'b1;
                        r_pulse <= '0;
                        r_tmo   <= '0;
                    end
                end
                ST_ISSUE: begin
                    r_pulse  <= r_pulse + 1'b1;
                    r_tmo    <= w_tmo_nxt;
                    r_stable <= '0;
                end
                ST_MONITOR: begin
                    r_tmo    <= w_tmo_nxt;
                    r_stable <= w_stable_nxt;
                    // Settling on the same cycle as the timeout still counts as success.
                    if (w_settled || w_timed_out) begin
                        r_ok <= w_settled;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode the async-reset state so a reset clears them without a clock edge.
    assign req_ready   = ((r_state == ST_IDLE) && !rst) ? w_grant : '0;
    assign icou        = (r_state == ST_ISSUE) ? r_cmd : CMD_NOP;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_REPORT) && r_ok;
    assign err         = (r_state == ST_REPORT) && !r_ok;
    assign done_id     = r_id;
    assign done_height = (r_state == ST_REPORT) ? tray_height : '0;

endmodule

// File: tb/tb_tray_move_sched.sv
// Drives random and directed tray moves; outputs are checked every cycle against a
// trace-based model that predicts grant order, icou pulse and the report cycle of each move.
module tb_tray_move_sched;

    localparam int NREQ = 4;
    localparam int CP   = 2;
    localparam int SC   = 16;
    localparam int TMO  = 64;
    localparam int HW   = 32;

    localparam int PAT_STATIC   = 0;
    localparam int PAT_RAMP     = 1;
    localparam int PAT_TOGGLE   = 2;
    localparam int PAT_BOUND    = 3;
    localparam int PAT_RANDSTEP = 4;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [4*NREQ-1:0] req_cmd;
    logic [NREQ-1:0] req_ready;
    logic [3:0]      icou;
    logic [HW-1:0]   tray_height;
    logic            busy;
    logic            done;
    logic [1:0]      done_id;
    logic [HW-1:0]   done_height;
    logic            err;

    tray_move_sched #(
        .NREQ        (NREQ),
        .CMD_PULSE   (CP),
        .SETTLE_CYC  (SC),
        .TIMEOUT_CYC (TMO),
        .HW          (HW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_cmd     (req_cmd),
        .req_ready   (req_ready),
        .icou        (icou),
        .tray_height (tray_height),
        .busy        (busy),
        .done        (done),
        .done_id     (done_id),
        .done_height (done_height),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic          chk_en = 1'b0;
    logic [3:0]    exp_ready, exp_icou;
    logic          exp_busy, exp_done, exp_err, exp_out;
    logic [1:0]    exp_id;
    logic [HW-1:0] exp_h;

    logic [HW-1:0] hb [0:TMO+1];
    int            mdl_ptr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("icou",      64'(icou),      64'(exp_icou));
            chk("busy",      64'(busy),      64'(exp_busy));
            chk("done",      64'(done),      64'(exp_done));
            chk("err",       64'(err),       64'(exp_err));
            if (exp_out) begin
                chk("done_id",     64'(done_id),     64'(exp_id));
                chk("done_height", 64'(done_height), 64'(exp_h));
            end
        end
    end

    function automatic int mdl_grant(input logic [3:0] vm, input int ptr);
        for (int off = 0; off < NREQ; off++) begin
            if (vm[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
        end
        return -1;
    endfunction

    // Report cycle (offset from accept): first monitor offset whose last SC height steps
    // were all unchanged, else the timeout offset.
    function automatic int mdl_report(input bit query, output bit ok);
        bit same;
        ok = 1'b1;
        if (query) return 1;
        for (int m = CP + 1; m <= TMO; m++) begin
            if (m - SC >= CP) begin
                same = 1'b1;
                for (int j = m - SC + 1; j <= m; j++) begin
                    if (hb[j] != hb[j-1]) same = 1'b0;
                end
                if (same) return m + 1;
            end
        end
        ok = 1'b0;
        return TMO + 1;
    endfunction

    task automatic build_trace(input int pat, input logic [HW-1:0] base);
        int lim;
        lim = $urandom_range(0, 60);
        for (int k = 0; k <= TMO + 1; k++) begin
            case (pat)
                PAT_RAMP:   hb[k] = (k * 5 >= 100) ? HW'(100) : HW'(k * 5);
                PAT_TOGGLE: hb[k] = (k % 2 == 1) ? ~base : base;
                PAT_BOUND:  hb[k] = (k < CP + SC) ? base : base + 1;
                PAT_RANDSTEP: begin
                    if (k == 0) hb[k] = base;
                    else hb[k] = (k < lim && $urandom_range(0, 3) == 0) ? hb[k-1] + 1 : hb[k-1];
                end
                default:    hb[k] = base;
            endcase
        end
    endtask

    task automatic run_txn(input logic [3:0] vm, input int pat, input logic [HW-1:0] base,
                           input bit transient, input int stop_at,
                           output int g, output int rpt, output bit ok);
        logic [3:0] cmd;
        bit         query;
        g     = mdl_grant(vm, mdl_ptr);
        cmd   = req_cmd[g*4 +: 4];
        query = (cmd == 4'h0);
        build_trace(pat, base);
        rpt     = mdl_report(query, ok);
        mdl_ptr = (g + 1) % NREQ;
        for (int k = 0; k <= rpt && (stop_at < 0 || k <= stop_at); k++) begin
            @(negedge clk);
            req_valid   = (transient && k > 0 && k < rpt) ? (vm | 4'($urandom)) : vm;
            tray_height = hb[k];
            exp_ready   = (k == 0) ? 4'(1 << g) : 4'h0;
            exp_icou    = (!query && k >= 1 && k <= CP) ? cmd : 4'h0;
            exp_busy    = (k > 0);
            exp_done    = (k == rpt) && ok;
            exp_err     = (k == rpt) && !ok;
            exp_out     = (k == rpt);
            exp_id      = 2'(g);
            exp_h       = hb[k];
            chk_en      = 1'b1;
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid   = '0;
            tray_height = $urandom;
            if (i == 0) begin
                for (int r = 0; r < NREQ; r++) begin
                    req_cmd[r*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                end
            end
            exp_ready = '0; exp_icou = '0; exp_busy = 1'b0;
            exp_done  = 1'b0; exp_err = 1'b0; exp_out = 1'b0;
            chk_en    = 1'b1;
        end
    endtask

    int g, rpt;
    bit ok;
    int rr_exp [4] = '{0, 1, 3, 0};

    initial begin
        rst         = 1'b1;
        req_valid   = 4'hF;
        req_cmd     = 16'h1111;
        tray_height = 32'd123;
        #3;
        chk("rst_req_ready",   64'(req_ready),   64'h0);
        chk("rst_icou",        64'(icou),        64'h0);
        chk("rst_busy",        64'(busy),        64'h0);
        chk("rst_done",        64'(done),        64'h0);
        chk("rst_err",         64'(err),         64'h0);
        chk("rst_done_id",     64'(done_id),     64'h0);
        chk("rst_done_height", 64'(done_height), 64'h0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;

        // Round-robin with 1011 held: grants 0,1,3,0, each a static-height move.
        for (int i = 0; i < 4; i++) begin
            run_txn(4'b1011, PAT_STATIC, 32'd9, 1'b0, -1, g, rpt, ok);
            chk("rr_grant", 64'(g), 64'(rr_exp[i]));
            if (i == 0) chk("pin_static_rpt", 64'(rpt), 64'd19);
        end

        gap(1);
        req_cmd = 16'h1111;
        run_txn(4'b0001, PAT_RAMP, 32'd0, 1'b0, -1, g, rpt, ok);
        chk("pin_ramp_rpt", 64'(rpt), 64'd37);
        chk("pin_ramp_h",   64'(hb[rpt]), 64'd100);

        gap(1);
        req_cmd = 16'h1011;
        run_txn(4'b0100, PAT_STATIC, 32'd55, 1'b0, -1, g, rpt, ok);
        chk("pin_query_rpt", 64'(rpt), 64'd1);

        gap(1);
        req_cmd = 16'h1111;
        run_txn(4'b0001, PAT_TOGGLE, 32'hA5A5_0000, 1'b0, -1, g, rpt, ok);
        chk("pin_tmo_rpt", 64'(rpt), 64'd65);
        chk("pin_tmo_ok",  64'(ok),  64'd0);
        run_txn(4'b0010, PAT_STATIC, 32'd3, 1'b0, -1, g, rpt, ok);
        chk("after_tmo_grant", 64'(g), 64'd1);

        gap(1);
        req_cmd = 16'h1111;
        run_txn(4'b1000, PAT_BOUND, 32'd7, 1'b0, -1, g, rpt, ok);
        chk("pin_bound_rpt", 64'(rpt), 64'd35);

        // Reset in the middle of the command pulse.
        gap(1);
        req_cmd = 16'h1111;
        run_txn(4'b0010, PAT_STATIC, 32'd4, 1'b0, 1, g, rpt, ok);
        #4;
        chk_en = 1'b0;
        rst    = 1'b1;
        #1;
        chk("midrst_icou",      64'(icou),      64'h0);
        chk("midrst_busy",      64'(busy),      64'h0);
        chk("midrst_done",      64'(done),      64'h0);
        chk("midrst_err",       64'(err),       64'h0);
        chk("midrst_req_ready", 64'(req_ready), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        mdl_ptr   = 0;
        run_txn(4'b1111, PAT_STATIC, 32'd8, 1'b0, -1, g, rpt, ok);
        chk("post_rst_grant", 64'(g), 64'd0);

        for (int t = 0; t < 40; t++) begin
            gap($urandom_range(0, 2));
            run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 4), $urandom,
                    1'($urandom_range(0, 1)), -1, g, rpt, ok);
        end

        gap(2);
        @(negedge clk);
        chk_en = 1'b0;
        #3;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
